// File: rtl/rtx_frame_sequencer_pkg.sv
// Shared ray-tracer frame definitions: default frame geometry, sequencer
// state encoding and the coordinate tag carried through the in-order queue.
package rtx_frame_sequencer_pkg;

  localparam int FRAME_WIDTH  = 1280;
  localparam int FRAME_HEIGHT = 720;

  typedef logic [1:0] rtx_seq_state_t;

  localparam rtx_seq_state_t S_IDLE  = 2'd0;
  localparam rtx_seq_state_t S_ISSUE = 2'd1;
  localparam rtx_seq_state_t S_DRAIN = 2'd2;
  localparam rtx_seq_state_t S_DONE  = 2'd3;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
  } rtx_tag_t;

  localparam int TAG_W = $bits(rtx_tag_t);

endpackage

// File: rtl/rtx_frame_sequencer_tag_fifo.sv
// In-order tag queue holding the coordinates of issued, not yet completed pixels.
// A pop on an empty queue is ignored; a push while full is accepted only with a pop.
module pixel_tag_fifo
  import rtx_frame_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = TAG_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_q];
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/rtx_frame_sequencer.sv
// Frame sequencer: raster-walks a frame into the ray pipeline under an in-flight
// cap and pairs in-order tracer completions with queued coordinates as fb writes.
module rtx_frame_sequencer
  import rtx_frame_sequencer_pkg::*;
#(
  parameter int WIDTH        = FRAME_WIDTH,
  parameter int HEIGHT       = FRAME_HEIGHT,
  parameter int MAX_INFLIGHT = 16,
  localparam int AW          = $clog2(WIDTH * HEIGHT),
  localparam int CW          = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          tracer_ready,
  input  logic          ray_done,
  input  logic [15:0]   rtx_pixel,
  output logic [10:0]   pixel_h_out,
  output logic [9:0]    pixel_v_out,
  output logic          pixel_valid,
  output logic [AW-1:0] fb_addr,
  output logic [15:0]   fb_data,
  output logic          fb_we,
  output logic          busy,
  output logic          frame_done,
  output logic          tag_underflow
);

  localparam logic [10:0] H_LAST  = 11'(WIDTH - 1);
  localparam logic [9:0]  V_LAST  = 10'(HEIGHT - 1);
  localparam logic [31:0] WIDTH_U = 32'(WIDTH);

  rtx_seq_state_t state_q, state_d;
  logic [10:0]    h_q, h_d;
  logic [9:0]     v_q, v_d;
  logic           pixel_valid_q;
  logic [10:0]    pixel_h_q;
  logic [9:0]     pixel_v_q;
  logic           fb_we_q;
  logic [AW-1:0]  fb_addr_q, fb_addr_d;
  logic [15:0]    fb_data_q;
  logic           tag_underflow_q;

  rtx_tag_t       push_tag, head_tag;
  logic [CW-1:0]  inflight;
  logic           fifo_empty, fifo_full;
  logic           issue, pop, last_pixel;
  logic [31:0]    row_base;

  // A completion in the same cycle frees a slot, so a full queue may still issue.
  assign issue      = (state_q == S_ISSUE) && tracer_ready && (!fifo_full || ray_done);
  assign pop        = ray_done && !fifo_empty;
  assign last_pixel = (h_q == H_LAST) && (v_q == V_LAST);
  assign push_tag   = '{h: h_q, v: v_q};

  pixel_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .W     (TAG_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (push_tag),
    .pop       (pop),
    .head      (head_tag),
    .count     (inflight),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign row_base  = {22'd0, head_tag.v} * WIDTH_U;
  assign fb_addr_d = row_base[AW-1:0] + AW'(head_tag.h);

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_ISSUE;
          h_d     = '0;
          v_d     = '0;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          if (last_pixel) begin
            state_d = S_DRAIN;
            h_d     = '0;
            v_d     = '0;
          end else if (h_q == H_LAST) begin
            h_d = '0;
            v_d = v_q + 10'd1;
          end else begin
            h_d = h_q + 11'd1;
          end
        end
      end
      S_DRAIN: begin
        if (inflight == '0 && !fb_we_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Issue stage and write stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      h_q             <= '0;
      v_q             <= '0;
      pixel_valid_q   <= 1'b0;
      pixel_h_q       <= '0;
      pixel_v_q       <= '0;
      fb_we_q         <= 1'b0;
      fb_addr_q       <= '0;
      fb_data_q       <= '0;
      tag_underflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      pixel_valid_q <= issue;
      if (issue) begin
        pixel_h_q <= h_q;
        pixel_v_q <= v_q;
      end
      fb_we_q <= pop;
      if (pop) begin
        fb_addr_q <= fb_addr_d;
        fb_data_q <= rtx_pixel;
      end
      if (ray_done && fifo_empty) tag_underflow_q <= 1'b1;
    end
  end

  assign pixel_valid   = pixel_valid_q;
  assign pixel_h_out   = pixel_h_q;
  assign pixel_v_out   = pixel_v_q;
  assign fb_we         = fb_we_q;
  assign fb_addr       = fb_addr_q;
  assign fb_data       = fb_data_q;
  assign busy          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign frame_done    = (state_q == S_DONE);
  assign tag_underflow = tag_underflow_q;

endmodule

// File: tb/tb_rtx_frame_sequencer.sv
// Bench for rtx_frame_sequencer on a 4x3 frame with four rays in flight.
module tb_rtx_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, tracer_ready, ray_done;
  logic [15:0] rtx_pixel;
  logic [10:0] pixel_h_out;
  logic [9:0]  pixel_v_out;
  logic        pixel_valid;
  logic [3:0]  fb_addr;
  logic [15:0] fb_data;
  logic        fb_we, busy, frame_done, tag_underflow;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rtx_frame_sequencer #(
    .WIDTH        (4),
    .HEIGHT       (3),
    .MAX_INFLIGHT (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .tracer_ready  (tracer_ready),
    .ray_done      (ray_done),
    .rtx_pixel     (rtx_pixel),
    .pixel_h_out   (pixel_h_out),
    .pixel_v_out   (pixel_v_out),
    .pixel_valid   (pixel_valid),
    .fb_addr       (fb_addr),
    .fb_data       (fb_data),
    .fb_we         (fb_we),
    .busy          (busy),
    .frame_done    (frame_done),
    .tag_underflow (tag_underflow)
  );

  typedef struct {
    logic        fs, tr, rd;
    logic [15:0] px;
    logic        pv;
    logic [10:0] h;
    logic [9:0]  v;
    logic        we;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        busy;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(int fs, int tr, int rd, int px, int pv, int h, int v,
                              int we, int addr, int data, int bz);
    vec_t r;
    r.fs = 1'(fs);  r.tr = 1'(tr);  r.rd = 1'(rd);  r.px = 16'(px);
    r.pv = 1'(pv);  r.h = 11'(h);   r.v = 10'(v);   r.we = 1'(we);
    r.addr = 4'(addr); r.data = 16'(data); r.busy = 1'(bz);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int due[$];
    int issued, writes, dones, nrd;

    rst = 1'b1; frame_start = 1'b0; tracer_ready = 1'b0; ray_done = 1'b0; rtx_pixel = '0;

    // fs tr rd px  | pv h v we addr data busy
    tbl[0]  = mk(1, 1, 0, 0,       0, 0, 0, 0, 0, 0,       1);
    tbl[1]  = mk(0, 1, 0, 0,       1, 0, 0, 0, 0, 0,       1);
    tbl[2]  = mk(0, 1, 0, 0,       1, 1, 0, 0, 0, 0,       1);
    tbl[3]  = mk(0, 1, 0, 0,       1, 2, 0, 0, 0, 0,       1);
    tbl[4]  = mk(0, 1, 0, 0,       1, 3, 0, 0, 0, 0,       1);
    tbl[5]  = mk(0, 1, 0, 0,       0, 3, 0, 0, 0, 0,       1);
    tbl[6]  = mk(0, 1, 1, 'hA001,  1, 0, 1, 1, 0, 'hA001,  1);
    tbl[7]  = mk(0, 1, 0, 0,       0, 0, 1, 0, 0, 'hA001,  1);
    tbl[8]  = mk(0, 0, 1, 'hB002,  0, 0, 1, 1, 1, 'hB002,  1);
    tbl[9]  = mk(0, 1, 0, 0,       1, 1, 1, 0, 1, 'hB002,  1);
    tbl[10] = mk(0, 1, 0, 0,       0, 1, 1, 0, 1, 'hB002,  1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pv",   32'(pixel_valid), 0);
    chk("rst_we",   32'(fb_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_uf",   32'(tag_underflow), 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      frame_start = tbl[i].fs; tracer_ready = tbl[i].tr;
      ray_done = tbl[i].rd; rtx_pixel = tbl[i].px;
      cycle();
      chk($sformatf("v%0d_pv", i),   32'(pixel_valid), 32'(tbl[i].pv));
      if (tbl[i].pv) begin
        chk($sformatf("v%0d_h", i),  32'(pixel_h_out), 32'(tbl[i].h));
        chk($sformatf("v%0d_v", i),  32'(pixel_v_out), 32'(tbl[i].v));
      end
      chk($sformatf("v%0d_we", i),   32'(fb_we), 32'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("v%0d_addr", i), 32'(fb_addr), 32'(tbl[i].addr));
        chk($sformatf("v%0d_data", i), 32'(fb_data), 32'(tbl[i].data));
      end
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_done", i), 32'(frame_done), 0);
      chk($sformatf("v%0d_uf", i),   32'(tag_underflow), 0);
    end

    // Asynchronous reset in the middle of a frame, no clock edge in between.
    frame_start = 1'b0; tracer_ready = 1'b0; ray_done = 1'b0; rtx_pixel = '0;
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_h",    32'(pixel_h_out), 0);
    chk("arst_v",    32'(pixel_v_out), 0);
    chk("arst_addr", 32'(fb_addr), 0);
    chk("arst_data", 32'(fb_data), 0);
    chk("arst_pv",   32'(pixel_valid), 0);
    @(negedge clk);
    rst = 1'b0;

    // Full frame, completions five cycles after issue, a stray frame_start mid-frame.
    issued = 0; writes = 0; dones = 0; nrd = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      frame_start  = (cyc == 0 || cyc == 7);
      tracer_ready = 1'b1;
      ray_done     = (due.size() > 0 && due[0] == cyc);
      rtx_pixel    = 16'hC000 + 16'(nrd);
      if (ray_done) begin
        void'(due.pop_front());
        nrd++;
      end
      cycle();
      if (pixel_valid) begin
        chk($sformatf("ff_h%0d", issued), 32'(pixel_h_out), 32'(issued % 4));
        chk($sformatf("ff_v%0d", issued), 32'(pixel_v_out), 32'(issued / 4));
        due.push_back(cyc + 5);
        issued++;
      end
      if (fb_we) begin
        chk($sformatf("ff_addr%0d", writes), 32'(fb_addr), 32'(writes));
        chk($sformatf("ff_data%0d", writes), 32'(fb_data), 32'(16'hC000 + 16'(writes)));
        writes++;
      end
      if (frame_done) begin
        chk("ff_done_after_writes", 32'(writes), 12);
        dones++;
      end
      if (cyc == 3) chk("ff_busy_mid", 32'(busy), 1);
    end
    frame_start = 1'b0; ray_done = 1'b0;
    chk("ff_issues",  32'(issued), 12);
    chk("ff_writes",  32'(writes), 12);
    chk("ff_dones",   32'(dones), 1);
    chk("ff_busy_end", 32'(busy), 0);
    chk("ff_uf",      32'(tag_underflow), 0);

    // Completion with nothing in flight.
    ray_done = 1'b1; rtx_pixel = 16'hDEAD;
    cycle();
    ray_done = 1'b0;
    chk("uf_set", 32'(tag_underflow), 1);
    chk("uf_we",  32'(fb_we), 0);
    repeat (3) cycle();
    chk("uf_sticky", 32'(tag_underflow), 1);
    chk("uf_we_idle", 32'(fb_we), 0);
    rst = 1'b1;
    #1;
    chk("uf_rst", 32'(tag_underflow), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rtx_frame_sequencer.md
# rtx_frame_sequencer

Frame-level controller for the ray-tracing datapath. On a frame start it walks every pixel of a WIDTH×HEIGHT frame in raster order and feeds coordinates to the ray maker / ray tracer pipeline, respecting a cap on rays in flight. Tracer completions arrive in issue order and carry no coordinates, so the block keeps an in-order tag queue of issued coordinates. It pairs each completed 565 pixel with its coordinates and emits a framebuffer write.

## Interface
- WIDTH, 1280, frame width in pixels
- HEIGHT, 720, frame height in pixels
- MAX_INFLIGHT, 16, max issued-but-uncompleted pixels; power of two, ≥2
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- frame_start  in  1  one-cycle pulse; begins a frame when idle
- tracer_ready  in  1  pipeline can accept a pixel this cycle
- ray_done  in  1  tracer result valid (in issue order)
- rtx_pixel  in  16  565 color accompanying ray_done
- pixel_h_out  out  11  issued column
- pixel_v_out  out  10  issued row
- pixel_valid  out  1  issue strobe; coordinates valid
- fb_addr  out  $clog2(WIDTH*HEIGHT)  write address = v*WIDTH + h
- fb_data  out  16  write data
- fb_we  out  1  write strobe
- busy  out  1  high from accepted frame_start until frame_done
- frame_done  out  1  one-cycle pulse at end of frame
- tag_underflow  out  1  sticky error: ray_done with empty tag queue

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: frame_start → ISSUE. Clear h=v=0 and inflight=0. busy=1.
- ISSUE: issue when tracer_ready && inflight<MAX_INFLIGHT.
  - On issue: pixel_valid=1 with current (h,v). Push (h,v) to the tag queue and advance the position.
  - Position advance: h<WIDTH-1 → h+1. Otherwise h=0, v+1.
  - Issuing (WIDTH-1,HEIGHT-1) → DRAIN.
- DRAIN: no issues. When inflight==0 and no write is pending → DONE.
- DONE: frame_done=1 for one cycle, busy=0, → IDLE.
- Completion, in any state: on ray_done, pop the queue head and register fb_addr, fb_data=rtx_pixel, fb_we=1.
- Simultaneous issue and completion: push and pop in the same cycle; inflight unchanged.
- ray_done with an empty queue: no pop, no write, set tag_underflow. The flag clears only on rst.
- frame_start while busy: ignored.
- inflight never exceeds MAX_INFLIGHT; the queue never overflows by construction.
- fb_addr arithmetic: v*WIDTH uses an unsigned constant multiply, truncated to the fb_addr width, then adds h.

## Timing
- Reset values: all outputs 0, state IDLE, queue empty, h=v=0, tag_underflow=0. Reset mid-frame discards the frame and all in-flight tags immediately.
- Start latency: frame_start at cycle t → first pixel_valid at t+1 at the earliest.
- Issue outputs are registered. pixel_valid at cycle t reflects the tracer_ready sampled at t-1 → the tracer's acceptance is registered one cycle late. The pipeline must tolerate one extra issue after deasserting tracer_ready.
- Full rate: one pixel per cycle. WIDTH*HEIGHT issues for a frame with no stalls.
- Write latency: ray_done at cycle t → fb_we/fb_addr/fb_data at t+1. fb_we is a single-cycle strobe per completion; back-to-back completions give back-to-back writes.
- frame_done fires the cycle after the last fb_we of the frame at the earliest.
- No backpressure from the framebuffer; a write is always accepted.

## Structure
- Shared package (existing rtx package): state enum `rtx_seq_state_t` and a coordinate tag struct `{h[10:0], v[9:0]}`. The frame constants already in the package supply the WIDTH/HEIGHT defaults.
- Sub-module: `pixel_tag_fifo`, a synchronous in-order FIFO.
  - Depth MAX_INFLIGHT, 21-bit entries.
  - Ports: push, pop, head, count, empty, full.
  - Asynchronous active-high reset.
  - Supports simultaneous push and pop when full or empty-with-push.
- Sequencer FSM, position counters and address register live in the top.

## Test plan
- WIDTH=4, HEIGHT=3, MAX_INFLIGHT=4, tracer_ready=1, completion 5 cycles after issue → 12 issues in raster order (0,0)…(3,2). 12 writes, addresses 0..11 in order with matching data. One frame_done; busy low afterwards.
- Tracer never completes → exactly 4 pixel_valid, then stall. Releasing one ray_done → exactly one further issue.
- ray_done in the same cycle as an issue while inflight=4 → issue proceeds, count stays 4, no overflow. fb_addr matches the oldest tag.
- ray_done pulse with no frame running → tag_underflow=1, fb_we stays 0. The flag persists until rst.
- frame_start pulsed during an active frame → ignored: addresses are not restarted and only one frame_done occurs.
- rst asserted mid-frame after 6 issues → all outputs 0 asynchronously. A new frame_start restarts at (0,0) with an empty queue.
